id_ex_pipe_reg: RTL and testbench

Parametrised elastic pipeline register placed between decode and execute, replacing the fixed ID/EX latch. It carries a control bundle and a data bundle under a valid/ready handshake, with an optional skid entry so `in_ready` is a registered signal. It also supports flush (bubble insertion) and a saturating back-pressure counter. Control bits presented downstream are forced to zero whenever no valid instruction is held, so a bubble cannot cause memory or register side effects.

---
 rtl/id_ex_pipe_reg_if.sv | 25 ++
 rtl/id_ex_pipe_reg.sv | 131 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-execute handshake bundle: valid/ready with control and data payloads.
// The decode/execute side uses master; the pipeline register uses slave.
interface id_ex_pipe_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 275
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// Elastic ID/EX pipeline register with optional skid entry, flush and a
// saturating back-pressure counter. Control bits are masked while no entry is valid.
module id_ex_pipe_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 275,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_pipe_reg_if.slave  bus,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic              main_vld_q, main_vld_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_vld_q, skid_vld_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_fire, out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = main_vld_q && bus.out_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (SKID != 0) begin
      // State is encoded by {main, skid} valid bits: 00 EMPTY, 10 ONE, 11 FULL.
      case ({main_vld_q, skid_vld_q})
        2'b00: begin
          if (in_fire) begin
            main_vld_d  = 1'b1;
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end
        end
        2'b10: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end else if (in_fire) begin
            skid_vld_d  = 1'b1;
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
          end else if (out_fire) begin
            main_vld_d = 1'b0;
          end
        end
        default: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_vld_d  = 1'b0;
          end
        end
      endcase
    end else begin
      if (in_fire) begin
        main_vld_d  = 1'b1;
        main_ctrl_d = bus.in_ctrl;
        main_data_d = bus.in_data;
      end else if (out_fire) begin
        main_vld_d = 1'b0;
      end
    end
    // Flush beats every handshake event, including a same-cycle input transfer.
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
    occ_d   = {1'b0, main_vld_d} + {1'b0, skid_vld_d};
    stall_d = (main_vld_q && !bus.out_ready) ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      occ_q       <= 2'd0;
      stall_q     <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      occ_q       <= occ_d;
      stall_q     <= stall_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;
      always_ff @(posedge clk) begin
        if (reset) rdy_q <= 1'b1;
        else       rdy_q <= !skid_vld_d;
      end
      assign bus.in_ready = rdy_q;
    end else begin : g_single
      assign bus.in_ready = !main_vld_q || bus.out_ready;
    end
  endgenerate

  assign bus.out_valid = main_vld_q;
  assign bus.out_ctrl  = main_ctrl_q & {CTRL_W{main_vld_q}};
  assign bus.out_data  = main_data_q;
  assign occupancy     = occ_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: skid-mode vector table with a scoreboard, then
// hand-written single-entry and counter-saturation sequences.
module tb_id_ex_pipe_reg;
  localparam int CW = 8;
  localparam int DW = 275;

  typedef logic [CW+DW-1:0] ent_t;
  typedef struct {
    logic       iv;
    logic       ordy;
    logic       fl;
    logic [4:0] rd;
    logic       e_ov;
    logic [1:0] e_occ;
    logic       e_ir;
    logic [15:0] e_st;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fl_a, fl_b, fl_c;
  logic [1:0]  occ_a, occ_b, occ_c;
  logic [15:0] st_a, st_b;
  logic [3:0]  st_c;
  int          total = 0;
  int          bad = 0;
  ent_t        sb[$];
  vec_t        tbl[$];
  ent_t        exp_e;
  logic        in_f, out_f;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.CTRL_W(CW), .DATA_W(DW)) ifa ();
  id_ex_pipe_reg_if #(.CTRL_W(CW), .DATA_W(DW)) ifb ();
  id_ex_pipe_reg_if #(.CTRL_W(CW), .DATA_W(DW)) ifc ();

  id_ex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .bus(ifa), .flush(fl_a), .occupancy(occ_a), .stall_cycles(st_a));
  id_ex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .bus(ifb), .flush(fl_b), .occupancy(occ_b), .stall_cycles(st_b));
  id_ex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .bus(ifc), .flush(fl_c), .occupancy(occ_c), .stall_cycles(st_c));

  function automatic logic [DW-1:0] data_of(input logic [4:0] rd);
    logic [63:0] b;
    b = 64'h0123_4567_89AB_CDE0 + {59'd0, rd};
    return {b, ~b, b ^ 64'hFFFF_0000_FFFF_0000, {b[31:0], b[63:32]},
            rd[3:0], rd, ~rd, rd + 5'd1};
  endfunction

  // MemWrite is always set so that masking of stale control is observable.
  function automatic logic [CW-1:0] ctrl_of(input logic [4:0] rd);
    return {rd[3:0], 4'b0100};
  endfunction

  function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                              input logic [4:0] rd, input logic ov, input logic [1:0] occ,
                              input logic ir, input logic [15:0] st);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.rd = rd;
    v.e_ov = ov; v.e_occ = occ; v.e_ir = ir; v.e_st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    fl_a = 1'b0; fl_b = 1'b0; fl_c = 1'b0;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b0; ifa.in_ctrl = '0; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b0; ifb.in_ctrl = '0; ifb.in_data = '0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.in_ctrl = '0; ifc.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst a out_valid", ifa.out_valid, 1'b0);
    chk("rst a out_ctrl", ifa.out_ctrl, 8'h00);
    chk("rst a out_data", ifa.out_data, '0);
    chk("rst a occupancy", occ_a, 2'd0);
    chk("rst a in_ready", ifa.in_ready, 1'b1);
    chk("rst a stall", st_a, 16'd0);
    chk("rst b in_ready", ifb.in_ready, 1'b1);
    chk("rst b out_valid", ifb.out_valid, 1'b0);
    chk("rst c occupancy", occ_c, 2'd0);
    chk("rst c stall", st_c, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    // Streaming: rd 1..8 back to back, then drain.
    for (int r = 1; r <= 8; r++) tbl.push_back(mk(1, 1, 0, 5'(r), 1, 2'd1, 1, 16'd0));
    tbl.push_back(mk(0, 1, 0, 5'd0, 0, 2'd0, 1, 16'd0));
    // Back-pressure: skid fills, third input held off, release in order.
    tbl.push_back(mk(1, 1, 0, 5'd1, 1, 2'd1, 1, 16'd0));
    tbl.push_back(mk(1, 0, 0, 5'd2, 1, 2'd2, 0, 16'd1));
    tbl.push_back(mk(1, 0, 0, 5'd3, 1, 2'd2, 0, 16'd2));
    tbl.push_back(mk(1, 0, 0, 5'd3, 1, 2'd2, 0, 16'd3));
    tbl.push_back(mk(1, 1, 0, 5'd3, 1, 2'd1, 1, 16'd3));
    tbl.push_back(mk(1, 1, 0, 5'd3, 1, 2'd1, 1, 16'd3));
    tbl.push_back(mk(0, 1, 0, 5'd0, 0, 2'd0, 1, 16'd3));
    // Flush while FULL with a pending input that must never appear.
    tbl.push_back(mk(1, 0, 0, 5'd9,  1, 2'd1, 1, 16'd3));
    tbl.push_back(mk(1, 0, 0, 5'd10, 1, 2'd2, 0, 16'd4));
    tbl.push_back(mk(1, 0, 1, 5'd11, 0, 2'd0, 1, 16'd5));
    tbl.push_back(mk(1, 1, 0, 5'd12, 1, 2'd1, 1, 16'd5));
    tbl.push_back(mk(0, 1, 0, 5'd0,  0, 2'd0, 1, 16'd5));
    // Flush in ONE drops an accepted same-cycle input.
    tbl.push_back(mk(1, 1, 0, 5'd13, 1, 2'd1, 1, 16'd5));
    tbl.push_back(mk(1, 0, 1, 5'd14, 0, 2'd0, 1, 16'd6));
    tbl.push_back(mk(0, 1, 0, 5'd0,  0, 2'd0, 1, 16'd6));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      ifa.in_valid  = tbl[i].iv;
      ifa.out_ready = tbl[i].ordy;
      fl_a          = tbl[i].fl;
      ifa.in_ctrl   = ctrl_of(tbl[i].rd);
      ifa.in_data   = data_of(tbl[i].rd);
      #1;
      in_f  = ifa.in_valid && ifa.in_ready;
      out_f = ifa.out_valid && ifa.out_ready;
      if (out_f) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb row %0d: unexpected output %0h, no entry outstanding", i, ifa.out_data);
        end else begin
          exp_e = sb.pop_front();
          chk($sformatf("sb row %0d out", i), {ifa.out_ctrl, ifa.out_data}, exp_e);
        end
      end
      if (fl_a) sb.delete();
      else if (in_f) sb.push_back({ctrl_of(tbl[i].rd), data_of(tbl[i].rd)});
      @(posedge clk);
      #1;
      chk($sformatf("row %0d out_valid", i), ifa.out_valid, tbl[i].e_ov);
      chk($sformatf("row %0d occupancy", i), occ_a, tbl[i].e_occ);
      chk($sformatf("row %0d in_ready", i), ifa.in_ready, tbl[i].e_ir);
      chk($sformatf("row %0d stall", i), st_a, tbl[i].e_st);
      if (!tbl[i].e_ov) chk($sformatf("row %0d masked ctrl", i), ifa.out_ctrl, 8'h00);
    end
    chk("sb drained", sb.size(), 0);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    fl_a = 1'b0;

    // Single-entry mode: combinational in_ready and replace-on-double-fire.
    ifb.in_valid = 1'b1; ifb.out_ready = 1'b0;
    ifb.in_ctrl = ctrl_of(5'd1); ifb.in_data = data_of(5'd1);
    #1;
    chk("b empty in_ready", ifb.in_ready, 1'b1);
    @(posedge clk); #1;
    chk("b load out_valid", ifb.out_valid, 1'b1);
    chk("b load out_data", ifb.out_data, data_of(5'd1));
    chk("b load occupancy", occ_b, 2'd1);
    chk("b stalled in_ready", ifb.in_ready, 1'b0);
    @(negedge clk);
    ifb.in_ctrl = ctrl_of(5'd2); ifb.in_data = data_of(5'd2);
    #1;
    chk("b held in_ready", ifb.in_ready, 1'b0);
    ifb.out_ready = 1'b1;
    #1;
    chk("b comb in_ready", ifb.in_ready, 1'b1);
    chk("b head data", ifb.out_data, data_of(5'd1));
    @(posedge clk); #1;
    chk("b replace out_valid", ifb.out_valid, 1'b1);
    chk("b replace out_data", ifb.out_data, data_of(5'd2));
    chk("b replace out_ctrl", ifb.out_ctrl, ctrl_of(5'd2));
    chk("b replace occupancy", occ_b, 2'd1);
    @(negedge clk);
    ifb.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b drain out_valid", ifb.out_valid, 1'b0);
    chk("b drain out_ctrl", ifb.out_ctrl, 8'h00);
    chk("b drain occupancy", occ_b, 2'd0);
    chk("b stall", st_b, 16'd0);

    // 4-bit counter saturation with out_valid held for 20 cycles.
    @(negedge clk);
    ifc.in_valid = 1'b1; ifc.out_ready = 1'b0;
    ifc.in_ctrl = ctrl_of(5'd5); ifc.in_data = data_of(5'd5);
    @(posedge clk); #1;
    chk("c load stall", st_c, 4'd0);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 14) chk("c stall 14", st_c, 4'd14);
      if (k == 15) chk("c stall 15", st_c, 4'd15);
      if (k == 16) chk("c stall sat 16", st_c, 4'd15);
    end
    chk("c stall sat 20", st_c, 4'd15);
    chk("c held out_valid", ifc.out_valid, 1'b1);
    chk("c held out_data", ifc.out_data, data_of(5'd5));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("c reset stall", st_c, 4'd0);
    chk("c reset out_valid", ifc.out_valid, 1'b0);
    chk("a reset stall", st_a, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
